// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the EXE ALU. Holds one decoded instruction behind a
// valid/ready handshake. It forwards MEM/WB results onto the ALU operands, selects the
// immediate or register operand, and inserts one bubble on a load-use hazard.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [2:0]        id_funct3,
    input  logic              id_subright,
    input  logic              id_use_imm,
    input  logic              id_is_load,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic [4:0]        mem_rd_addr,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [4:0]        wb_rd_addr,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [4:0]        shamt,
    output logic [2:0]        funct3,
    output logic              subright,
    output logic [4:0]        ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [4:0]        rs1_addr_q, rs1_addr_d;
    logic [4:0]        rs2_addr_q, rs2_addr_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
    logic [XLEN-1:0]   rs2_val_q, rs2_val_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              subright_q, subright_d;
    logic              use_imm_q, use_imm_d;
    logic              is_load_q, is_load_d;
    logic              reg_write_q, reg_write_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic              advance;
    logic              hazard;
    logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

    // Operand source selection: x0 reads zero, MEM beats WB, else the held value.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] addr, input logic [XLEN-1:0] val,
                                                input logic [4:0] m_rd, input logic m_we,
                                                input logic [XLEN-1:0] m_res,
                                                input logic [4:0] w_rd, input logic w_we,
                                                input logic [XLEN-1:0] w_dat);
        logic [XLEN-1:0] res;
        if (addr == 5'd0) begin
            res = '0;
        end else if (m_we && (m_rd == addr)) begin
            res = m_res;
        end else if (w_we && (w_rd == addr)) begin
            res = w_dat;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Handshake and load-use hazard detection against the held instruction.
    always_comb begin
        ex_valid     = (state_q == StFull);
        ex_is_load   = ex_valid & is_load_q;
        ex_reg_write = ex_valid & reg_write_q;
        advance      = ~ex_valid | ex_ready;
        hazard       = ex_is_load && (rd_addr_q != 5'd0) &&
                       ((id_rs1_addr == rd_addr_q) || (!id_use_imm && (id_rs2_addr == rd_addr_q)));
        id_ready     = advance & ~hazard & ~flush;
    end

    // Next-state: flush beats advance; a hazard turns the advance into a counted bubble.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rd_addr_d     = rd_addr_q;
        rs1_val_d     = rs1_val_q;
        rs2_val_d     = rs2_val_q;
        imm_d         = imm_q;
        funct3_d      = funct3_q;
        subright_d    = subright_q;
        use_imm_d     = use_imm_q;
        is_load_d     = is_load_q;
        reg_write_d   = reg_write_q;
        stall_count_d = stall_count_q;

        if (flush) begin
            state_d = StEmpty;
        end else if (advance) begin
            if (hazard) begin
                state_d = StEmpty;
                if (stall_count_q != {CNT_W{1'b1}}) begin
                    stall_count_d = stall_count_q + CNT_W'(1);
                end
            end else if (id_valid) begin
                state_d     = StFull;
                pc_d        = id_pc;
                rs1_addr_d  = id_rs1_addr;
                rs2_addr_d  = id_rs2_addr;
                rd_addr_d   = id_rd_addr;
                imm_d       = id_imm;
                funct3_d    = id_funct3;
                subright_d  = id_subright;
                use_imm_d   = id_use_imm;
                is_load_d   = id_is_load;
                reg_write_d = id_reg_write;
                // WB writes the regfile this same edge, so the read port saw stale data.
                rs1_val_d   = (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs1_addr))
                              ? wb_data : id_rs1_data;
                rs2_val_d   = (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs2_addr))
                              ? wb_data : id_rs2_data;
            end else begin
                state_d = StEmpty;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StEmpty;
            pc_q          <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_addr_q     <= '0;
            rs1_val_q     <= '0;
            rs2_val_q     <= '0;
            imm_q         <= '0;
            funct3_q      <= '0;
            subright_q    <= 1'b0;
            use_imm_q     <= 1'b0;
            is_load_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_addr_q     <= rd_addr_d;
            rs1_val_q     <= rs1_val_d;
            rs2_val_q     <= rs2_val_d;
            imm_q         <= imm_d;
            funct3_q      <= funct3_d;
            subright_q    <= subright_d;
            use_imm_q     <= use_imm_d;
            is_load_q     <= is_load_d;
            reg_write_q   <= reg_write_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Forwarded ALU operands; stays live while the instruction is held.
    always_comb begin
        rs1_fwd     = fwd_sel(rs1_addr_q, rs1_val_q, mem_rd_addr, mem_reg_write, mem_result,
                              wb_rd_addr, wb_reg_write, wb_data);
        rs2_fwd     = fwd_sel(rs2_addr_q, rs2_val_q, mem_rd_addr, mem_reg_write, mem_result,
                              wb_rd_addr, wb_reg_write, wb_data);
        rs1_data    = rs1_fwd;
        rs2_data    = use_imm_q ? imm_q : rs2_fwd;
        shamt       = use_imm_q ? imm_q[4:0] : rs2_fwd[4:0];
        ex_pc       = pc_q;
        funct3      = funct3_q;
        subright    = subright_q;
        ex_rd_addr  = rd_addr_q;
        stall_count = stall_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, forwarding, load-use bubble, hold/flush, shifts.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]  id_funct3;
    logic        id_subright, id_use_imm, id_is_load, id_reg_write;
    logic        flush, ex_ready;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, rs1_data, rs2_data;
    logic [4:0]  shamt;
    logic [2:0]  funct3;
    logic        subright;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_is_load;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_funct3(id_funct3), .id_subright(id_subright), .id_use_imm(id_use_imm),
        .id_is_load(id_is_load), .id_reg_write(id_reg_write), .flush(flush),
        .ex_ready(ex_ready), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .shamt(shamt), .funct3(funct3), .subright(subright),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .stall_count(stall_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id;
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_funct3 = 0; id_subright = 0;
        id_use_imm = 0; id_is_load = 0; id_reg_write = 0;
    endtask

    task automatic idle_fwd;
        mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1a, input logic [4:0] rs2a,
                         input logic [4:0] rda, input logic [31:0] rs1d, input logic [31:0] rs2d,
                         input logic [31:0] imm, input logic [2:0] f3, input logic sr,
                         input logic ui, input logic ld, input logic rw);
        id_valid = 1; id_pc = pc; id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rda;
        id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm; id_funct3 = f3;
        id_subright = sr; id_use_imm = ui; id_is_load = ld; id_reg_write = rw;
    endtask

    task automatic test_reset;
        rst = 1; flush = 0; ex_ready = 1; idle_id(); idle_fwd();
        tick(); tick();
        rst = 0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL reset_ex_valid: got %0h expected 0", ex_valid); end
        checks++; if (stall_count !== 16'd0) begin errors++;
            $display("FAIL reset_stall_count: got %0h expected 0", stall_count); end
        checks++; if (rs2_data !== 32'd0 || shamt !== 5'd0) begin errors++;
            $display("FAIL reset_rs2_shamt: got %0h/%0h expected 0/0", rs2_data, shamt); end
        checks++; if (id_ready !== 1'b1) begin errors++;
            $display("FAIL reset_id_ready: got %0h expected 1", id_ready); end
    endtask

    task automatic test_back_to_back;
        // ADD x3,x1,x2
        drive(32'h100, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd_addr !== 5'd3) begin errors++;
            $display("FAIL b2b_first_capture: got v=%0h pc=%0h rd=%0h expected 1/100/3",
                     ex_valid, ex_pc, ex_rd_addr); end
        checks++; if (rs1_data !== 32'd10 || rs2_data !== 32'd20) begin errors++;
            $display("FAIL b2b_first_operands: got %0h/%0h expected a/14", rs1_data, rs2_data); end
        // ADD x4,x3,x3 with stale regfile values
        drive(32'h104, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_id_ready: got %0h expected 1", id_ready); end
        tick();
        mem_rd_addr = 5'd3; mem_reg_write = 1; mem_result = 32'h55;
        #1;
        checks++; if (rs1_data !== 32'h55 || rs2_data !== 32'h55) begin errors++;
            $display("FAIL b2b_mem_forward: got %0h/%0h expected 55/55", rs1_data, rs2_data); end
        idle_fwd();
    endtask

    task automatic test_load_use;
        // LW x5, 4(x1)
        drive(32'h200, 5'd1, 5'd0, 5'd5, 32'h100, 32'd0, 32'd4, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checks++; if (ex_is_load !== 1'b1 || ex_reg_write !== 1'b1) begin errors++;
            $display("FAIL lu_load_held: got ld=%0h rw=%0h expected 1/1", ex_is_load, ex_reg_write); end
        // ADDI x6,x5,1
        drive(32'h204, 5'd5, 5'd0, 5'd6, 32'd0, 32'd0, 32'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++;
            $display("FAIL lu_hazard_id_ready: got %0h expected 0", id_ready); end
        tick();
        mem_rd_addr = 5'd5; mem_reg_write = 1; mem_result = 32'h104;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_is_load !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble: got v=%0h rw=%0h ld=%0h expected 0/0/0",
                     ex_valid, ex_reg_write, ex_is_load); end
        checks++; if (stall_count !== 16'd1) begin errors++;
            $display("FAIL lu_stall_count: got %0h expected 1", stall_count); end
        checks++; if (id_ready !== 1'b1) begin errors++;
            $display("FAIL lu_id_ready_after_bubble: got %0h expected 1", id_ready); end
        tick();
        idle_id();
        mem_reg_write = 0; wb_rd_addr = 5'd5; wb_reg_write = 1; wb_data = 32'h1234;
        #1;
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204) begin errors++;
            $display("FAIL lu_consumer_valid: got v=%0h pc=%0h expected 1/204", ex_valid, ex_pc); end
        checks++; if (rs1_data !== 32'h1234 || rs2_data !== 32'd1) begin errors++;
            $display("FAIL lu_wb_forward: got %0h/%0h expected 1234/1", rs1_data, rs2_data); end
        checks++; if (stall_count !== 16'd1) begin errors++;
            $display("FAIL lu_single_bubble: got %0h expected 1", stall_count); end
        idle_fwd();
    endtask

    task automatic test_priority;
        // ADD x8,x7,x0 with nonzero garbage on the x0 read port
        drive(32'h300, 5'd7, 5'd0, 5'd8, 32'h77, 32'h99, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_id(); ex_ready = 0;
        mem_rd_addr = 5'd7; mem_reg_write = 1; mem_result = 32'hA;
        wb_rd_addr = 5'd7; wb_reg_write = 1; wb_data = 32'hB;
        #1;
        checks++; if (rs1_data !== 32'hA) begin errors++;
            $display("FAIL prio_mem_over_wb: got %0h expected a", rs1_data); end
        checks++; if (rs2_data !== 32'd0) begin errors++;
            $display("FAIL prio_x0_source: got %0h expected 0", rs2_data); end
        mem_rd_addr = 5'd0; mem_result = 32'hC;
        #1;
        checks++; if (rs1_data !== 32'hB || rs2_data !== 32'd0) begin errors++;
            $display("FAIL prio_wb_and_mem_x0: got %0h/%0h expected b/0", rs1_data, rs2_data); end
        idle_fwd();
        #1;
        checks++; if (rs1_data !== 32'h77) begin errors++;
            $display("FAIL prio_registered: got %0h expected 77", rs1_data); end
        ex_ready = 1;
    endtask

    task automatic test_hold_flush;
        drive(32'h400, 5'd1, 5'd2, 5'd10, 32'd1, 32'd2, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_ready = 0;
        drive(32'h404, 5'd1, 5'd2, 5'd11, 32'd3, 32'd4, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++;
            $display("FAIL hold_id_ready: got %0h expected 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rd_addr !== 5'd10) begin
            errors++;
            $display("FAIL hold_registers: got v=%0h pc=%0h rd=%0h expected 1/400/a",
                     ex_valid, ex_pc, ex_rd_addr); end
        flush = 1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++;
            $display("FAIL flush_id_ready: got %0h expected 0", id_ready); end
        tick();
        flush = 0;
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'h400) begin errors++;
            $display("FAIL flush_empty: got v=%0h pc=%0h expected 0/400", ex_valid, ex_pc); end
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++;
            $display("FAIL flush_refill_ready: got %0h expected 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h404 || ex_rd_addr !== 5'd11) begin
            errors++;
            $display("FAIL flush_not_consumed: got v=%0h pc=%0h rd=%0h expected 1/404/b",
                     ex_valid, ex_pc, ex_rd_addr); end
        ex_ready = 1;
    endtask

    task automatic test_shift;
        // SRAI x9,x1,4
        drive(32'h500, 5'd1, 5'd4, 5'd9, 32'h8000_0000, 32'hFF, 32'h404, 3'd5, 1'b1, 1'b1, 1'b0,
              1'b1);
        tick();
        checks++; if (shamt !== 5'd4 || rs2_data !== 32'h404) begin errors++;
            $display("FAIL srai_operands: got shamt=%0h rs2=%0h expected 4/404", shamt, rs2_data); end
        checks++; if (subright !== 1'b1 || funct3 !== 3'd5) begin errors++;
            $display("FAIL srai_ctrl: got sr=%0h f3=%0h expected 1/5", subright, funct3); end
        // SRA x9,x1,x8 with x8 written back on the capture edge
        drive(32'h504, 5'd1, 5'd8, 5'd9, 32'h8000_0000, 32'd0, 32'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        wb_rd_addr = 5'd8; wb_reg_write = 1; wb_data = 32'h23;
        tick();
        idle_id(); idle_fwd();
        #1;
        checks++; if (shamt !== 5'd3 || rs2_data !== 32'h23) begin errors++;
            $display("FAIL sra_wb_bypass: got shamt=%0h rs2=%0h expected 3/23", shamt, rs2_data); end
    endtask

    task automatic test_reset_mid_full;
        drive(32'h600, 5'd13, 5'd0, 5'd12, 32'h5A, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_id(); ex_ready = 0;
        checks++; if (ex_valid !== 1'b1 || rs1_data !== 32'h5A) begin errors++;
            $display("FAIL rst_pre_full: got v=%0h rs1=%0h expected 1/5a", ex_valid, rs1_data); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (ex_valid !== 1'b0 || stall_count !== 16'd0 || rs1_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_full: got v=%0h stall=%0h rs1=%0h expected 0/0/0",
                     ex_valid, stall_count, rs1_data); end
        checks++; if (ex_pc !== 32'd0 || ex_rd_addr !== 5'd0) begin errors++;
            $display("FAIL rst_fields: got pc=%0h rd=%0h expected 0/0", ex_pc, ex_rd_addr); end
        ex_ready = 1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_hold_flush();
        test_shift();
        test_reset_mid_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
